// File: rtl/intwb_arbiter_pkg.sv
// Shared constants and types for the integer writeback arbiter.
// Holds the core configuration type, the long-unit indices and the
// default starvation limit.
package intwb_arbiter_pkg;

    // Core configuration; only the XLEN field is used here.
    typedef struct packed {
        logic [31:0] XLEN;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{XLEN: 32'd32};

    localparam int unsigned NUM_LONG_WB      = 2;
    localparam int unsigned LWB_MDU          = 0;
    localparam int unsigned LWB_FPU          = 1;
    localparam int unsigned STARVE_LIMIT_DEF = 8;
    localparam int unsigned REG_W            = 5;

endpackage

// File: rtl/intwb_arbiter_if.sv
// Bus bundle between the W stage, long-latency units, decode and the
// integer writeback arbiter.
//   slave  : arbiter side (requests in, write port / stalls out)
//   master : pipeline / unit side
interface intwb_arbiter_if
    import intwb_arbiter_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_LONG = NUM_LONG_WB
);
    logic                       PipeValidW;
    logic [4:0]                 PipeRdW;
    logic [XLEN-1:0]            PipeResultW;
    logic [NUM_LONG-1:0]        LongValid;
    logic [NUM_LONG*5-1:0]      LongRd;
    logic [NUM_LONG*XLEN-1:0]   LongResult;
    logic [NUM_LONG-1:0]        LongAccept;
    logic                       IssueLongE;
    logic [4:0]                 IssueRdE;
    logic [4:0]                 Rs1D;
    logic [4:0]                 Rs2D;
    logic [4:0]                 RdD;
    logic                       RegWriteD;
    logic                       ScoreboardStallD;
    logic                       HoldW;
    logic                       RegWriteW;
    logic [4:0]                 RdW;
    logic [XLEN-1:0]            ResultW;

    modport slave (
        input  PipeValidW, PipeRdW, PipeResultW,
        input  LongValid, LongRd, LongResult,
        input  IssueLongE, IssueRdE, Rs1D, Rs2D, RdD, RegWriteD,
        output LongAccept, ScoreboardStallD, HoldW,
        output RegWriteW, RdW, ResultW
    );

    modport master (
        output PipeValidW, PipeRdW, PipeResultW,
        output LongValid, LongRd, LongResult,
        output IssueLongE, IssueRdE, Rs1D, Rs2D, RdD, RegWriteD,
        input  LongAccept, ScoreboardStallD, HoldW,
        input  RegWriteW, RdW, ResultW
    );

endinterface

// File: rtl/intwb_arbiter_rrarb.sv
// Round-robin arbiter: picks the first request at or after ptr.
//   req : request vector
//   ptr : highest-priority index this cycle
//   gnt : one-hot grant (zero when no request)
module rrarb #(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic found;

    // Scan offsets from ptr; the first hit wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (!found && req[j] && (((32'(ptr) + k) % N) == j)) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/intwb_arbiter.sv
// Integer register-file write port arbiter with long-op scoreboard.
//   clk, reset : core clock, synchronous active-high reset
//   bus        : W-stage request, long-unit requests/accepts, issue info,
//                decode hazard query, HoldW and the regfile write port
module intwb_arbiter
    import intwb_arbiter_pkg::*;
#(
    parameter cvw_t        P            = CVW_DEFAULT,
    parameter int unsigned NUM_LONG     = NUM_LONG_WB,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    intwb_arbiter_if.slave   bus
);

    localparam int unsigned XLEN  = P.XLEN;
    localparam int unsigned PTR_W = (NUM_LONG > 1) ? $clog2(NUM_LONG) : 1;
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [PTR_W-1:0]    rr_ptr, rr_ptr_nxt, gnt_ptr;
    logic [CNT_W-1:0]    starve_cnt, starve_cnt_nxt;
    logic                hold, hold_nxt;
    logic [31:0]         pending, pending_nxt, set_mask, clr_mask;
    logic                pipe_win, long_any, any_valid;
    logic [NUM_LONG-1:0] long_req, long_gnt;
    logic [REG_W-1:0]    gnt_rd;
    logic [XLEN-1:0]     gnt_result;

    assign any_valid = |bus.LongValid;
    assign pipe_win  = ~reset & ~hold & bus.PipeValidW;
    // Long units compete only when the pipeline does not take the port.
    assign long_req  = (reset | pipe_win) ? '0 : bus.LongValid;

    rrarb #(.N(NUM_LONG), .PTR_W(PTR_W)) u_rrarb (
        .req (long_req),
        .ptr (rr_ptr),
        .gnt (long_gnt)
    );

    assign long_any = |long_gnt;

    // Select the granted unit's payload and its successor pointer.
    always_comb begin
        gnt_rd     = '0;
        gnt_result = '0;
        gnt_ptr    = rr_ptr;
        for (int i = 0; i < int'(NUM_LONG); i++) begin
            if (long_gnt[i]) begin
                gnt_rd     = bus.LongRd[i*5 +: 5];
                gnt_result = bus.LongResult[i*int'(XLEN) +: XLEN];
                gnt_ptr    = PTR_W'((i + 1) % int'(NUM_LONG));
            end
        end
    end

    // Register-file write port.
    assign bus.RegWriteW  = pipe_win | long_any;
    assign bus.RdW        = pipe_win ? bus.PipeRdW     : gnt_rd;
    assign bus.ResultW    = pipe_win ? bus.PipeResultW : gnt_result;
    assign bus.LongAccept = long_gnt;
    assign bus.HoldW      = hold;

    // No same-cycle bypass: a stall clears the cycle after the write.
    assign bus.ScoreboardStallD = pending[bus.Rs1D] | pending[bus.Rs2D] |
                                  (bus.RegWriteD & pending[bus.RdD]);

    // Next-state: pointer, starvation counter, hold and scoreboard.
    always_comb begin
        rr_ptr_nxt     = rr_ptr;
        starve_cnt_nxt = starve_cnt;
        hold_nxt       = hold;
        set_mask       = '0;
        clr_mask       = '0;

        if (long_any) begin
            rr_ptr_nxt = gnt_ptr;
        end

        if (long_any) begin
            starve_cnt_nxt = '0;
        end else if (any_valid && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
        end

        // Hold drops after the forced grant, or if the requester withdrew.
        if (long_any || !any_valid) begin
            hold_nxt = 1'b0;
        end else if (starve_cnt_nxt == CNT_W'(STARVE_LIMIT)) begin
            hold_nxt = 1'b1;
        end

        // x0 is never tracked; set takes priority over clear.
        for (int r = 1; r < 32; r++) begin
            set_mask[r] = bus.IssueLongE && (bus.IssueRdE == 5'(r));
            clr_mask[r] = long_any && (gnt_rd == 5'(r));
        end
        pending_nxt = ((pending & ~clr_mask) | set_mask) & ~32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= '0;
            starve_cnt <= '0;
            hold       <= 1'b0;
            pending    <= '0;
        end else begin
            rr_ptr     <= rr_ptr_nxt;
            starve_cnt <= starve_cnt_nxt;
            hold       <= hold_nxt;
            pending    <= pending_nxt;
        end
    end

endmodule

// File: doc/intwb_arbiter.md
Name: intwb_arbiter

Overview:
- Shares the single integer register-file write port between the in-order pipeline writeback and long-latency integer-result producers. Long-latency producers are the iterative MDU and the FPU integer results (fcvt, integer divide on fdivsqrt).
- Keeps a destination-register scoreboard for in-flight long ops, so decode stalls on RAW/WAW hazards against results that cannot be forwarded.
- Sits between the W-stage result mux and regfile; drives the hazard unit's decode and writeback stalls.

Parameters:
- P, cvw_t, core configuration; only P.XLEN is used.
- NUM_LONG, 2, number of long-latency requesters (0 = MDU, 1 = FPU integer).
- STARVE_LIMIT, 8, consecutive denied cycles before a long requester forces a pipeline writeback hold.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- PipeValidW  in  1  in-order W-stage register write request (RegWrite qualified)
- PipeRdW  in  5  W-stage destination
- PipeResultW  in  P.XLEN  W-stage result
- LongValid  in  NUM_LONG  long unit has a result pending
- LongRd  in  NUM_LONG*5  destination per long unit
- LongResult  in  NUM_LONG*P.XLEN  result per long unit
- LongAccept  out  NUM_LONG  one-hot; result written this cycle, unit may drop or advance
- IssueLongE  in  1  a long op leaves E this cycle (already qualified by ~StallE & ~FlushE)
- IssueRdE  in  5  destination of issued long op
- Rs1D, Rs2D, RdD  in  5 each  decode-stage register fields
- RegWriteD  in  1  decode instruction writes rd
- ScoreboardStallD  out  1  decode must stall
- HoldW  out  1  hazard unit must stall W (pipeline write deferred)
- RegWriteW  out  1  register-file write enable
- RdW  out  5  register-file write address
- ResultW  out  P.XLEN  register-file write data

Behaviour:
- Write port (combinational from inputs and state):
  - HoldW=0 and PipeValidW=1: pipeline wins.
  - Otherwise the first LongValid at or after RRPtr (round-robin) wins.
  - No request: RegWriteW=0, RdW=0, ResultW=0.
- LongAccept[i]=1 exactly when unit i is granted. Units hold Valid/Rd/Result stable until accepted. Accept occurs in the same cycle as the write.
- RRPtr: on any long grant to unit i, RRPtr <= (i+1) mod NUM_LONG next cycle. It does not change otherwise.
- Starvation counter (clog2(STARVE_LIMIT+1) bits, saturating):
  - Increments each cycle any LongValid is high and no long grant occurs.
  - Clears on any long grant.
- HoldW is registered. It is set next cycle when the counter reaches STARVE_LIMIT and any LongValid remains.
- While HoldW=1, the pipeline is denied and one long grant occurs. HoldW clears the cycle after that grant. Pipeline data stays stable because W is stalled.
- Scoreboard: 32-bit Pending register, bit 0 forced 0.
  - Set: IssueLongE & IssueRdE!=0 sets Pending[IssueRdE].
  - Clear: a long grant clears Pending[LongRd of the granted unit].
  - Same register set and cleared in one cycle: set wins.
- ScoreboardStallD = Pending[Rs1D] | Pending[Rs2D] | (RegWriteD & Pending[RdD]). This is combinational, with no bypass from a same-cycle long write; the stall drops the cycle after the write.
- Long result with Rd=0: accepted and RegWriteW=1 with RdW=0 (regfile ignores), no scoreboard effect.
- Pipeline write with PipeRdW=0: passed through unchanged.
- Reset (synchronous): Pending=0, RRPtr=0, counter=0, HoldW=0. While reset is high, all grants and RegWriteW are forced to 0. Reset mid-operation discards pending scoreboard state; long units are reset by the same signal.
- Only one unit can be granted per cycle; LongAccept is never multi-hot.

Decomposition:
- Shared package (cvw): NUM_LONG_WB constant, long-unit index localparams (LWB_MDU=0, LWB_FPU=1), and the STARVE_LIMIT default.
- Natural sub-module: rrarb, a parameterized round-robin arbiter (request vector plus pointer to one-hot grant), reusable elsewhere.
- Scoreboard and starvation logic stay in intwb_arbiter.

Test Plan:
- Reset, then Pipe-only traffic:
  - Stimulus: PipeValidW=1, PipeRdW=5, PipeResultW=0x1234.
  - Required: RegWriteW=1, RdW=5, ResultW=0x1234 same cycle; LongAccept=00.
- Issue MDU op with IssueRdE=10, then decode Rs1D=10:
  - ScoreboardStallD=1 until LongValid[0]=1 (pipe idle) is accepted with RdW=10.
  - Stall=0 the following cycle; Pending[10]=0.
- Both long units valid with the pipe idle for 4 cycles, each re-presenting a new result immediately after accept:
  - Grants alternate 01,10,01,10 starting with RRPtr=0.
- PipeValidW held 1 continuously with LongValid[1]=1:
  - After 8 denied cycles HoldW=1 next cycle; LongAccept=10 in the held cycle.
  - HoldW=0 the cycle after; pipe write resumes unchanged.
- Same-cycle IssueLongE with IssueRdE=7 and long grant of LongRd=7:
  - Pending[7] remains 1.
- IssueRdE=0 and LongRd=0 grant:
  - Pending stays 0, ScoreboardStallD=0 for Rs1D=0.
- Assert reset while Pending=0x0000_0400 and HoldW=1:
  - Next cycle Pending=0, HoldW=0, RRPtr=0, RegWriteW=0.
